// File: rtl/prq_pkg.sv
// Shared types for the posted-receive-queue matcher: FSM states, entry layout
// at the default widths, and the default sizing constants.
package prq_pkg;

    localparam int PRQ_DEPTH     = 16;
    localparam int PRQ_COMM_BIT  = 4;
    localparam int PRQ_RANK_BIT  = 8;
    localparam int PRQ_TAG_BIT   = 8;
    localparam int PRQ_PTR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        RESP  = 2'd2
    } prq_state_e;

    // Entry layout at default widths; the top re-declares it with its own widths.
    typedef struct packed {
        logic                     valid;
        logic [PRQ_COMM_BIT-1:0]  comm;
        logic [PRQ_RANK_BIT-1:0]  src;
        logic [PRQ_TAG_BIT-1:0]   tag;
        logic                     src_any;
        logic                     tag_any;
        logic [PRQ_PTR_WIDTH-1:0] ptr;
    } prq_entry_t;

endpackage

// File: rtl/prq_first_match.sv
// Lowest-set-bit priority encoder over the per-entry hit vector; index 0 is
// the oldest entry, so the lowest set bit is the MPI-order winner.
module prq_first_match #(
    parameter int DEPTH = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] hit_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |hit_i;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/prq_match_table.sv
// Posted-receive match table: ordered entry array with compaction on hit,
// wildcard source/tag matching and a three-state lookup FSM.
module prq_match_table
    import prq_pkg::*;
#(
    parameter int DEPTH     = PRQ_DEPTH,
    parameter int COMM_BIT  = PRQ_COMM_BIT,
    parameter int RANK_BIT  = PRQ_RANK_BIT,
    parameter int TAG_BIT   = PRQ_TAG_BIT,
    parameter int PTR_WIDTH = PRQ_PTR_WIDTH,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    input  logic [COMM_BIT-1:0]  ins_comm,
    input  logic [RANK_BIT-1:0]  ins_src,
    input  logic [TAG_BIT-1:0]   ins_tag,
    input  logic                 ins_src_any,
    input  logic                 ins_tag_any,
    input  logic [PTR_WIDTH-1:0] ins_ptr,
    input  logic                 find_valid,
    output logic                 find_ready,
    input  logic [COMM_BIT-1:0]  find_comm,
    input  logic [RANK_BIT-1:0]  find_src,
    input  logic [TAG_BIT-1:0]   find_tag,
    output logic                 res_valid,
    output logic                 res_found,
    output logic [PTR_WIDTH-1:0] res_ptr,
    output logic [CNT_W-1:0]     count,
    output logic                 empty,
    output logic                 full,
    output logic                 ins_drop
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                 valid;
        logic [COMM_BIT-1:0]  comm;
        logic [RANK_BIT-1:0]  src;
        logic [TAG_BIT-1:0]   tag;
        logic                 src_any;
        logic                 tag_any;
        logic [PTR_WIDTH-1:0] ptr;
    } entry_t;

    entry_t               tbl_q [DEPTH];
    entry_t               tbl_d [DEPTH];
    entry_t               new_entry;
    prq_state_e           state_q, state_d;
    logic [COMM_BIT-1:0]  env_comm_q;
    logic [RANK_BIT-1:0]  env_src_q;
    logic [TAG_BIT-1:0]   env_tag_q;
    logic [CNT_W-1:0]     count_q, count_d, wr_idx;
    logic                 res_found_q;
    logic [PTR_WIDTH-1:0] res_ptr_q;
    logic                 ins_drop_q;
    logic [DEPTH-1:0]     hit_vec;
    logic [IDX_W-1:0]     hit_idx;
    logic                 hit_any;
    logic                 ins_fire, rm;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign ins_ready = !full;
    assign ins_fire  = ins_valid && !full;
    assign rm        = (state_q == MATCH) && hit_any;
    assign count     = count_q;
    assign res_found = res_found_q;
    assign res_ptr   = res_ptr_q;
    assign ins_drop  = ins_drop_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = tbl_q[i].valid && (tbl_q[i].comm == env_comm_q)
                      && (tbl_q[i].src_any || (tbl_q[i].src == env_src_q))
                      && (tbl_q[i].tag_any || (tbl_q[i].tag == env_tag_q));
        end
    end

    prq_first_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_first_match (
        .hit_i (hit_vec),
        .idx_o (hit_idx),
        .any_o (hit_any)
    );

    // Compaction first, then the insert lands on the first free slot of the
    // compacted array, so a same-edge insert/remove keeps the array dense.
    always_comb begin
        new_entry = '{valid: 1'b1, comm: ins_comm, src: ins_src, tag: ins_tag,
                      src_any: ins_src_any, tag_any: ins_tag_any, ptr: ins_ptr};
        wr_idx    = rm ? count_q - CNT_W'(1) : count_q;
        for (int i = 0; i < DEPTH; i++) begin
            tbl_d[i] = tbl_q[i];
            if (rm && (i >= int'(hit_idx))) begin
                if (i < DEPTH - 1) tbl_d[i] = tbl_q[(i < DEPTH - 1) ? i + 1 : i];
                else               tbl_d[i] = '0;
            end
            if (ins_fire && (CNT_W'(i) == wr_idx)) tbl_d[i] = new_entry;
        end
        count_d = count_q + (ins_fire ? CNT_W'(1) : '0) - (rm ? CNT_W'(1) : '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (find_valid) state_d = MATCH;
            MATCH:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        find_ready = (state_q == IDLE);
        res_valid  = (state_q == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            env_comm_q  <= '0;
            env_src_q   <= '0;
            env_tag_q   <= '0;
            res_found_q <= 1'b0;
            res_ptr_q   <= '0;
            ins_drop_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ins_drop_q <= ins_valid && full;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_d[i];
            if (state_q == IDLE && find_valid) begin
                env_comm_q <= find_comm;
                env_src_q  <= find_src;
                env_tag_q  <= find_tag;
            end
            if (state_q == MATCH) begin
                res_found_q <= hit_any;
                res_ptr_q   <= hit_any ? tbl_q[hit_idx].ptr : '0;
            end else if (state_q == RESP) begin
                res_found_q <= 1'b0;
                res_ptr_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prq_match_table.sv
// Scenario bench for prq_match_table: expected lookup results are queued when
// a find is issued and compared when res_valid appears.
module tb_prq_match_table;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              ins_valid, ins_ready, ins_src_any, ins_tag_any;
    logic [3:0]        ins_comm;
    logic [7:0]        ins_src, ins_tag;
    logic [31:0]       ins_ptr;
    logic              find_valid, find_ready;
    logic [3:0]        find_comm;
    logic [7:0]        find_src, find_tag;
    logic              res_valid, res_found;
    logic [31:0]       res_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty, full, ins_drop;

    typedef struct {
        logic        found;
        logic [31:0] ptr;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prq_match_table dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_comm(ins_comm),
        .ins_src(ins_src), .ins_tag(ins_tag), .ins_src_any(ins_src_any),
        .ins_tag_any(ins_tag_any), .ins_ptr(ins_ptr),
        .find_valid(find_valid), .find_ready(find_ready), .find_comm(find_comm),
        .find_src(find_src), .find_tag(find_tag),
        .res_valid(res_valid), .res_found(res_found), .res_ptr(res_ptr),
        .count(count), .empty(empty), .full(full), .ins_drop(ins_drop)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drive_ins(input logic [3:0] c, input logic [7:0] s, input logic [7:0] t,
                             input logic sa, input logic ta, input logic [31:0] p);
        ins_valid = 1'b1; ins_comm = c; ins_src = s; ins_tag = t;
        ins_src_any = sa; ins_tag_any = ta; ins_ptr = p;
    endtask

    task automatic ins(input logic [3:0] c, input logic [7:0] s, input logic [7:0] t,
                       input logic sa, input logic ta, input logic [31:0] p);
        drive_ins(c, s, t, sa, ta, p);
        @(negedge clk);
        ins_valid = 1'b0;
    endtask

    // Issues a lookup in the current (IDLE) cycle; returns at the MATCH-cycle negedge.
    task automatic start_find(input logic [3:0] c, input logic [7:0] s, input logic [7:0] t,
                              input logic ef, input logic [31:0] ep);
        int k = 0;
        while (!find_ready && k < 10) begin @(negedge clk); k++; end
        checks++;
        if (!find_ready) begin
            errors++; $display("FAIL find_ready_wait: find_ready=%0b required 1", find_ready);
        end
        find_valid = 1'b1; find_comm = c; find_src = s; find_tag = t;
        sb.push_back('{found: ef, ptr: ep});
        @(negedge clk);
        find_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_lat);
        int k = 0;
        exp_t e;
        while (!res_valid && k < 8) begin @(negedge clk); k++; end
        checks++;
        if (!res_valid || k != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: res_valid=%0b after %0d cycles, required 1 after %0d",
                     name, res_valid, k, exp_lat);
        end
        if (sb.size() == 0) begin
            checks++; errors++; $display("FAIL %s_sb: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (res_found !== e.found || res_ptr !== e.ptr) begin
            errors++;
            $display("FAIL %s_result: found=%0b ptr=%h required found=%0b ptr=%h",
                     name, res_found, res_ptr, e.found, e.ptr);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || find_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after: res_valid=%0b find_ready=%0b required 0/1",
                     name, res_valid, find_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ins_ready !== 1'b1 || find_ready !== 1'b1 || res_valid !== 1'b0 ||
            res_found !== 1'b0 || res_ptr !== 32'h0 || count !== '0 ||
            empty !== 1'b1 || full !== 1'b0 || ins_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset: ins_rdy=%0b find_rdy=%0b rv=%0b rf=%0b rp=%h cnt=%0d e=%0b f=%0b drop=%0b required 1 1 0 0 0 0 1 0 0",
                     ins_ready, find_ready, res_valid, res_found, res_ptr, count, empty, full, ins_drop);
        end
    endtask

    task automatic test_exact();
        ins(4'd1, 8'd5, 8'd7, 1'b0, 1'b0, 32'h1000);
        checks++;
        if (count !== CNT_W'(1) || empty !== 1'b0) begin
            errors++; $display("FAIL exact_count_pre: count=%0d empty=%0b required 1/0", count, empty);
        end
        start_find(4'd1, 8'd5, 8'd7, 1'b1, 32'h1000);
        wait_result("exact", 1);
        checks++;
        if (count !== '0 || empty !== 1'b1) begin
            errors++; $display("FAIL exact_count_post: count=%0d empty=%0b required 0/1", count, empty);
        end
    endtask

    task automatic test_wildcard_order();
        ins(4'd1, 8'd0, 8'd7, 1'b1, 1'b0, 32'hA0);
        ins(4'd1, 8'd5, 8'd7, 1'b0, 1'b0, 32'hB0);
        start_find(4'd1, 8'd5, 8'd7, 1'b1, 32'hA0);
        wait_result("wild_first", 1);
        start_find(4'd1, 8'd5, 8'd7, 1'b1, 32'hB0);
        wait_result("wild_second", 1);
        start_find(4'd1, 8'd5, 8'd7, 1'b0, 32'h0);
        wait_result("wild_miss", 1);
    endtask

    task automatic test_comm_isolation();
        ins(4'd2, 8'd5, 8'd7, 1'b0, 1'b0, 32'hC0);
        start_find(4'd1, 8'd5, 8'd7, 1'b0, 32'h0);
        wait_result("comm_iso", 1);
        checks++;
        if (count !== CNT_W'(1)) begin
            errors++; $display("FAIL comm_iso_count: count=%0d required 1", count);
        end
        // tag wildcard on a different tag with matching comm still hits
        ins(4'd2, 8'd9, 8'd3, 1'b0, 1'b1, 32'hC1);
        start_find(4'd2, 8'd9, 8'd44, 1'b1, 32'hC1);
        wait_result("tag_any", 1);
        do_reset();
    endtask

    task automatic test_full_drop();
        for (int i = 0; i < DEPTH; i++) ins(4'd5, 8'(i), 8'd0, 1'b0, 1'b0, 32'h100 + i);
        checks++;
        if (full !== 1'b1 || ins_ready !== 1'b0 || count !== CNT_W'(DEPTH)) begin
            errors++; $display("FAIL full_state: full=%0b ins_ready=%0b count=%0d required 1/0/%0d",
                               full, ins_ready, count, DEPTH);
        end
        ins(4'd5, 8'd99, 8'd0, 1'b0, 1'b0, 32'hDEAD);
        checks++;
        if (ins_drop !== 1'b1 || count !== CNT_W'(DEPTH)) begin
            errors++; $display("FAIL drop_pulse: ins_drop=%0b count=%0d required 1/%0d", ins_drop, count, DEPTH);
        end
        @(negedge clk);
        checks++;
        if (ins_drop !== 1'b0) begin
            errors++; $display("FAIL drop_single: ins_drop=%0b required 0", ins_drop);
        end
        start_find(4'd5, 8'd3, 8'd0, 1'b1, 32'h103);
        wait_result("full_hit", 1);
        checks++;
        if (ins_ready !== 1'b1 || full !== 1'b0 || count !== CNT_W'(DEPTH - 1)) begin
            errors++; $display("FAIL full_free: ins_ready=%0b full=%0b count=%0d required 1/0/%0d",
                               ins_ready, full, count, DEPTH - 1);
        end
        start_find(4'd5, 8'd99, 8'd0, 1'b0, 32'h0);
        wait_result("dropped_absent", 1);
        do_reset();
    endtask

    task automatic test_concurrent();
        ins(4'd3, 8'd0, 8'd0, 1'b1, 1'b1, 32'h10);
        ins(4'd4, 8'd0, 8'd0, 1'b1, 1'b1, 32'h11);
        ins(4'd3, 8'd0, 8'd0, 1'b1, 1'b1, 32'h12);
        ins(4'd3, 8'd0, 8'd0, 1'b1, 1'b1, 32'h13);
        start_find(4'd4, 8'd1, 8'd1, 1'b1, 32'h11);
        drive_ins(4'd3, 8'd0, 8'd0, 1'b1, 1'b1, 32'h14);
        @(negedge clk);
        ins_valid = 1'b0;
        wait_result("concurrent", 0);
        checks++;
        if (count !== CNT_W'(4)) begin
            errors++; $display("FAIL concurrent_count: count=%0d required 4", count);
        end
        start_find(4'd3, 8'd0, 8'd0, 1'b1, 32'h10); wait_result("order0", 1);
        start_find(4'd3, 8'd0, 8'd0, 1'b1, 32'h12); wait_result("order1", 1);
        start_find(4'd3, 8'd0, 8'd0, 1'b1, 32'h13); wait_result("order2", 1);
        start_find(4'd3, 8'd0, 8'd0, 1'b1, 32'h14); wait_result("order3", 1);
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL concurrent_empty: empty=%0b required 1", empty);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        ins(4'd6, 8'd1, 8'd2, 1'b0, 1'b0, 32'h77);
        start_find(4'd6, 8'd1, 8'd2, 1'b1, 32'h77);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            if (res_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen || count !== '0 || empty !== 1'b1) begin
            errors++; $display("FAIL reset_mid: res_seen=%0b count=%0d empty=%0b required 0/0/1", seen, count, empty);
        end
        start_find(4'd6, 8'd1, 8'd2, 1'b0, 32'h0);
        wait_result("reset_mid_miss", 1);
    endtask

    initial begin
        rst = 1'b1; ins_valid = 1'b0; find_valid = 1'b0;
        ins_comm = '0; ins_src = '0; ins_tag = '0; ins_src_any = 1'b0; ins_tag_any = 1'b0;
        ins_ptr = '0; find_comm = '0; find_src = '0; find_tag = '0;
        test_reset();
        test_exact();
        test_wildcard_order();
        test_comm_isolation();
        test_full_drop();
        test_concurrent();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prq_match_table.md
# prq_match_table

Parametrised posted-receive-queue matcher for the MPI message-matching path. The processor inserts posted receives, each tagged with communicator, source rank and tag, with optional ANY_SOURCE/ANY_TAG wildcards. The network side presents incoming envelopes. The block returns the oldest matching posted receive's data pointer and removes that entry, preserving MPI ordering semantics. It sits between the Nios receive-request interface and the packetizer's arrival path.

## Interface
- DEPTH, 16: number of posted-receive entries (2..64).
- COMM_BIT, 4: communicator-ID width.
- RANK_BIT, 8: source-rank width.
- TAG_BIT, 8: tag width.
- PTR_WIDTH, 32: data-pointer width.
- CNT_W, $clog2(DEPTH+1): occupancy width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ins_valid  in  1  insert request.
- ins_ready  out  1  insert accepted when ins_valid&ins_ready.
- ins_comm  in  COMM_BIT  communicator.
- ins_src  in  RANK_BIT  source rank.
- ins_tag  in  TAG_BIT  tag.
- ins_src_any  in  1  ANY_SOURCE wildcard.
- ins_tag_any  in  1  ANY_TAG wildcard.
- ins_ptr  in  PTR_WIDTH  receive buffer pointer.
- find_valid  in  1  envelope lookup request.
- find_ready  out  1  lookup accepted when find_valid&find_ready.
- find_comm / find_src / find_tag  in  COMM_BIT / RANK_BIT / TAG_BIT  arriving envelope.
- res_valid  out  1  one-cycle result strobe.
- res_found  out  1  hit; res_valid&!res_found means miss.
- res_ptr  out  PTR_WIDTH  matched pointer; 0 on miss.
- count  out  CNT_W  valid entries.
- empty, full  out  1  count==0, count==DEPTH.
- ins_drop  out  1  one-cycle pulse: ins_valid while full.

## Operation
- Storage is an ordered array; index 0 is oldest. Valid entries always occupy indices 0..count-1.
- Insert: writes to index count and increments count.
- Match rule for entry e:
  - comm must be equal; comm is never a wildcard.
  - src must be equal, or e.src_any.
  - tag must be equal, or e.tag_any.
  - Only valid entries qualify.
- The lowest matching index wins (oldest first).
- On a hit, the winning entry is removed by compaction: entries above the hit index shift down by one, and count decrements.
- FSM states:
  - IDLE: find_ready=1. Lookup accept → MATCH, envelope registered.
  - MATCH: all entries compared in parallel; priority-encode → RESP. The result and the removal commit at the edge leaving MATCH.
  - RESP: res_valid=1 → IDLE.
- Miss on an empty table still traverses MATCH/RESP, with uniform latency.
- Simultaneous insert and compaction at the same edge: the new entry lands at index count-1, and count is unchanged.
- ins_ready = !full. There is no bypass: a removal pending in the same cycle does not free a slot early.
- Inserts are independent of FSM state.
- Occupancy never exceeds DEPTH and never wraps below 0.

## Timing
- Reset values:
  - ins_ready=1, find_ready=1.
  - res_valid=0, res_found=0, res_ptr=0.
  - count=0, empty=1, full=0, ins_drop=0.
  - FSM in IDLE; all valid bits cleared.
- Lookup accepted in cycle T: res_valid is high in cycle T+2 only, and find_ready returns high in T+3. Maximum throughput is one lookup per 3 cycles.
- Visibility of inserts to a lookup accepted at T:
  - An insert accepted in T or earlier is visible.
  - An insert accepted in T+1 (MATCH) is not visible.
- count, empty and full update the cycle after the edge that changed them. The post-removal count is visible in RESP.
- rst in any state aborts a lookup in flight: no res_valid, table cleared at the next edge.

## Structure
- Package prq_pkg holds:
  - the entry struct {valid, comm, src, tag, src_any, tag_any, ptr};
  - FSM state enum (IDLE, MATCH, RESP);
  - default width constants.
- Sub-module prq_first_match: DEPTH-bit hit vector → lowest-set index plus any-hit flag. Purely combinational, parameterised on DEPTH.
- Top level holds the entry array, compaction/insert logic, counters and FSM.

## Test plan
- Exact match: insert {comm=1,src=5,tag=7,ptr=0x1000}; find {1,5,7} → T+2 res_found=1, res_ptr=0x1000, count 1→0.
- Wildcard and ordering:
  - insert {1,ANY,7,0xA0}, then {1,5,7,0xB0};
  - find {1,5,7} → 0xA0;
  - repeat → 0xB0;
  - third → miss, res_ptr=0.
- Communicator isolation: insert {2,5,7,0xC0}; find {1,5,7} → miss, count stays 1.
- Full/drop: DEPTH inserts → full=1, ins_ready=0; an extra ins_valid → ins_drop pulse, count=DEPTH. A hit then frees a slot and ins_ready returns.
- Concurrent insert/remove:
  - fill indices 0..3 with ptr 0x10..0x13;
  - find matching index 1 while inserting 0x14 in MATCH;
  - → res_ptr=0x11, count=4, order 0x10, 0x12, 0x13, 0x14.
- Reset mid-lookup: assert rst in MATCH → no res_valid, count=0, empty=1; the next find misses.
